// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer producing HI/LO; all 32-bit add/sub work is
// borrowed from the CPU's shared ALU through the alu_* port while busy is high.
module mdu_seq #(
  parameter int W     = 32,
  parameter int ITERS = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] rs,
  input  logic [W-1:0] rt,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         dz,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [5:0]   alu_fun,
  output logic         alu_sign,
  input  logic [W-1:0] alu_z,
  output logic [2:0]   dbg_state_o
);

  // Handshake: start is sampled only while idle (busy low); busy stays high from the
  // cycle after start through the done cycle, and done is a single-cycle pulse with
  // hi/lo/dz valid from that cycle on. A start seen while busy is dropped.

  localparam int CW = $clog2(ITERS);
  localparam logic [5:0] FUN_ADD = 6'b000000;
  localparam logic [5:0] FUN_SUB = 6'b000001;

  typedef enum logic [2:0] {
    S_IDLE, S_NEGA, S_NEGB, S_ITER, S_FIXL, S_FIXH, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]    op_q, op_d;
  logic [W-1:0]  rs_q, rs_d, rt_q, rt_d;
  logic [W-1:0]  a_q, a_d;      // multiplicand or divisor magnitude
  logic [W-1:0]  phi_q, phi_d;  // product high half or partial remainder
  logic [W-1:0]  plo_q, plo_d;  // multiplier/product low half or dividend/quotient
  logic [CW-1:0] cnt_q, cnt_d;
  logic          negq_q, negq_d, negr_q, negr_d;
  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic          dz_q, dz_d;

  logic          is_signed, is_div;
  logic [W-1:0]  sh;
  logic          carry, borrow;

  assign is_signed = op_q[0];
  assign is_div    = op_q[1];
  assign sh        = {phi_q[W-2:0], plo_q[W-1]};
  assign carry     = (phi_q[W-1] & a_q[W-1]) | ((phi_q[W-1] | a_q[W-1]) & ~alu_z[W-1]);
  assign borrow    = (~sh[W-1] & a_q[W-1]) | (~(sh[W-1] ^ a_q[W-1]) & alu_z[W-1]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_NEGA;
      S_NEGA: state_d = S_NEGB;
      S_NEGB: state_d = S_ITER;
      S_ITER: if (cnt_q == CW'(ITERS - 1)) state_d = S_FIXL;
      S_FIXL: state_d = S_FIXH;
      S_FIXH: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU requests; any cycle not needing a real operation asks for 0+0.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_fun = FUN_ADD;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    case (state_q)
      S_NEGA: if (is_signed && rs_q[W-1]) begin
        alu_b = rs_q; alu_fun = FUN_SUB;
      end
      S_NEGB: if (is_signed && rt_q[W-1]) begin
        alu_b = rt_q; alu_fun = FUN_SUB;
      end
      S_ITER: begin
        alu_b = a_q;
        if (is_div) begin
          alu_a = sh; alu_fun = FUN_SUB;
        end else begin
          alu_a = phi_q;
        end
      end
      S_FIXL: if (!dz_q && is_signed && negq_q) begin
        alu_b = plo_q; alu_fun = FUN_SUB;
      end
      S_FIXH: if (!dz_q && is_signed) begin
        if (is_div ? negr_q : (negq_q && plo_q == '0)) begin
          alu_b = phi_q; alu_fun = FUN_SUB;
        end
      end
      default: ;
    endcase
  end

  assign alu_sign    = 1'b0;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dz          = dz_q;
  assign dbg_state_o = state_q;

  always_comb begin
    op_d   = op_q;   rs_d   = rs_q;   rt_d  = rt_q;  a_d  = a_q;
    phi_d  = phi_q;  plo_d  = plo_q;  cnt_d = cnt_q;
    negq_d = negq_q; negr_d = negr_q;
    hi_d   = hi_q;   lo_d   = lo_q;   dz_d  = dz_q;
    case (state_q)
      S_IDLE: if (start) begin
        op_d   = op;
        rs_d   = rs;
        rt_d   = rt;
        negq_d = rs[W-1] ^ rt[W-1];
        negr_d = rs[W-1];
        dz_d   = op[1] && (rt == '0);
      end
      S_NEGA: plo_d = (is_signed && rs_q[W-1]) ? alu_z : rs_q;
      S_NEGB: begin
        a_d   = (is_signed && rt_q[W-1]) ? alu_z : rt_q;
        phi_d = '0;
        cnt_d = '0;
      end
      S_ITER: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div) begin
          if (phi_q[W-1] || !borrow) begin
            phi_d = alu_z; plo_d = {plo_q[W-2:0], 1'b1};
          end else begin
            phi_d = sh;    plo_d = {plo_q[W-2:0], 1'b0};
          end
        end else if (plo_q[0]) begin
          phi_d = {carry, alu_z[W-1:1]};
          plo_d = {alu_z[0], plo_q[W-1:1]};
        end else begin
          phi_d = {1'b0, phi_q[W-1:1]};
          plo_d = {phi_q[0], plo_q[W-1:1]};
        end
      end
      S_FIXL: begin
        if (dz_q)                        lo_d = '1;
        else if (is_signed && negq_q)    lo_d = alu_z;
        else                             lo_d = plo_q;
      end
      S_FIXH: begin
        if (dz_q)                        hi_d = rs_q;
        else if (is_signed && is_div)    hi_d = negr_q ? alu_z : phi_q;
        else if (is_signed && negq_q)    hi_d = (plo_q == '0) ? alu_z : ~phi_q;
        else                             hi_d = phi_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= '0; rs_q   <= '0; rt_q  <= '0; a_q  <= '0;
      phi_q  <= '0; plo_q  <= '0; cnt_q <= '0;
      negq_q <= 1'b0; negr_q <= 1'b0;
      hi_q   <= '0; lo_q   <= '0; dz_q  <= 1'b0;
    end else begin
      op_q   <= op_d;   rs_q   <= rs_d;   rt_q  <= rt_d;  a_q  <= a_d;
      phi_q  <= phi_d;  plo_q  <= plo_d;  cnt_q <= cnt_d;
      negq_q <= negq_d; negr_q <= negr_d;
      hi_q   <= hi_d;   lo_q   <= lo_d;   dz_q  <= dz_d;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: drives directed and random ops, models the shared ALU, and
// scores hi/lo/dz and the fixed 37-cycle latency against a 64-bit arithmetic model.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] rs = '0, rt = '0;
  logic        busy, done, dz, alu_sign;
  logic [31:0] hi, lo, alu_a, alu_b, alu_z;
  logic [5:0]  alu_fun;
  logic [2:0]  dbg_state;

  mdu_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
    .alu_z(alu_z), .dbg_state_o(dbg_state)
  );

  // shared ALU stand-in
  assign alu_z = (alu_fun == 6'd1) ? alu_a - alu_b : alu_a + alu_b;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [64:0] exp_q[$];
  int          exp_cyc_q[$];
  int          total = 0, bad = 0, done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o[1] && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    case (o)
      2'd0: begin up = {32'd0, a} * {32'd0, b}; return {1'b0, up}; end
      2'd1: begin p = sa * sb; return {1'b0, 64'(p)}; end
      2'd2: return {1'b0, a % b, a / b};
      default: begin
        q = sa / sb;
        r = sa % sb;
        return {1'b0, 32'(r), 32'(q)};
      end
    endcase
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      check("alu_fun_legal", 64'(alu_fun == 6'd0 || alu_fun == 6'd1), 64'd1);
      check("alu_sign", 64'(alu_sign), 64'd0);
      if (!busy) begin
        check("idle_alu_a", 64'(alu_a), 64'd0);
        check("idle_alu_b", 64'(alu_b), 64'd0);
        check("idle_alu_fun", 64'(alu_fun), 64'd0);
      end
      if (done) begin
        logic [64:0] e;
        int          c0;
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e  = exp_q.pop_front();
          c0 = exp_cyc_q.pop_front();
          check("hi", 64'(hi), 64'(e[63:32]));
          check("lo", 64'(lo), 64'(e[31:0]));
          check("dz", 64'(dz), 64'(e[64]));
          check("latency", 64'(cyc - c0), 64'd37);
          check("busy_at_done", 64'(busy), 64'd1);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    exp_q.push_back(ref_model(o, a, b));
    exp_cyc_q.push_back(cyc);
    @(negedge clk);
    start = 1'b0;
    rs = $urandom; rt = $urandom; op = 2'($urandom_range(0, 3));
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    issue(o, a, b);
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [31:0] a, b;
    logic [1:0]  o;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_fun", 64'(alu_fun), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // directed cases
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'd1, 32'hFFFF_FFFD, 32'h0000_0007);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(2'd1, 32'h0000_0000, 32'hFFFF_FFFB);
    run_op(2'd2, 32'd100, 32'd7);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'd2, 32'h0000_1234, 32'd0);
    run_op(2'd3, 32'h0000_1234, 32'd0);
    run_op(2'd3, 32'hFFFF_1234, 32'd0);
    run_op(2'd0, 32'd3, 32'd5);
    run_op(2'd2, 32'hFFFF_FFFF, 32'h8000_0000);

    // restarts while busy (cycle 5) and in the done cycle must be ignored
    d0 = done_cnt;
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'd3; rs = 32'd77; rt = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (31) @(negedge clk);
    start = 1'b1; op = 2'd2; rs = 32'd99; rt = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (45) @(negedge clk);
    check("restart_done_count", 64'(done_cnt - d0), 64'd1);
    check("restart_stays_idle", 64'(busy), 64'd0);

    // asynchronous reset in the middle of ITER
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    d0 = done_cnt;
    issue(2'd1, 32'hFFFF_FFFD, 32'h0000_0007);
    repeat (11) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("arst_no_done", 64'(done_cnt - d0), 64'd0);
    run_op(2'd2, 32'd100, 32'd7);

    // random ops
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 32'($urandom_range(0, 255));
        1: a = 32'hFFFF_FFFF - 32'($urandom_range(0, 255));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      run_op(o, a, b);
    end

    wait_idle();
    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
